// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter: sends one command byte host->device over the PS/2 open-drain pair.
// Latency: INHIBIT_CYCLES of clock inhibit, then 11 device clocks; result pulse 1 cycle after fall #11.
// Backpressure: tx_ready low from the cycle after accept until IDLE; tx_valid while busy is ignored.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   tx_data/tx_valid/tx_ready byte request handshake (accept = tx_valid & tx_ready)
//   ps2_clk_in, ps2_dat_in   raw line levels (asynchronous, synchronized internally)
//   ps2_clk_oe, ps2_dat_oe   1 = pull the line low, 0 = release
//   busy                     transaction in progress
//   tx_done, tx_error        1-cycle result pulses (ack / nack or timeout)
//
// Build option: define PS2_TX_RETRY_EN to retry a failed byte up to MAX_RETRIES
// extra times before reporting tx_error. Without it the first failure is final.
module ps2_host_transmitter #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_TIMEOUT  = 750000,
   parameter int FRAME_TIMEOUT  = 100000,
   parameter int MAX_RETRIES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_INHIBIT = 3'd1;
   localparam logic [2:0] S_REQ     = 3'd2;
   localparam logic [2:0] S_DATA    = 3'd3;
   localparam logic [2:0] S_ACK     = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
   localparam logic [2:0] S_ERR     = 3'd6;

   localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
   localparam logic [19:0] FRAME_LAST = 20'(FRAME_TIMEOUT - 1);
   localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);

`ifdef PS2_TX_RETRY_EN
   localparam logic RETRY_EN = 1'b1;
`else
   localparam logic RETRY_EN = 1'b0;
`endif

   // line synchronizers; reset to the idle-high level so no false fall appears
   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic dat_s1_q, dat_s2_q;
   logic fall;

   logic [2:0]  state_q, state_d;
   logic [7:0]  data_q, data_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [19:0] tmo_q, tmo_d;
   logic [3:0]  retry_q, retry_d;
   logic        clk_oe_q, dat_oe_q, dat_oe_d;
   logic        done_q, err_q, busy_q;
   logic        accept, fail;
   logic [9:0]  frame;

   assign fall     = clk_prev_q & ~clk_s2_q;
   assign tx_ready = ~busy_q & ~rst;
   assign accept   = tx_valid & tx_ready;
   // index 0 = data bit0 ... 8 = odd parity, 9 = stop (released)
   assign frame    = {1'b1, ~^data_q, data_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_dat_in;
         dat_s2_q   <= dat_s1_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      bit_cnt_d = bit_cnt_q;
      retry_d   = retry_q;
      dat_oe_d  = dat_oe_q;
      tmo_d     = (&tmo_q) ? tmo_q : tmo_q + 20'd1;
      fail      = 1'b0;

      case (state_q)
         S_IDLE: begin
            tmo_d     = '0;
            bit_cnt_d = '0;
            if (accept) begin
               data_d  = tx_data;
               retry_d = '0;
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (tmo_q == INH_LAST) begin
               state_d   = S_REQ;
               tmo_d     = '0;
               bit_cnt_d = '0;
               dat_oe_d  = 1'b1;   // start bit 0 held while the clock is released
            end
         end
         S_REQ: begin
            if (fall) begin
               state_d   = S_DATA;
               bit_cnt_d = 4'd1;
               tmo_d     = '0;     // frame timeout runs from fall #1
               dat_oe_d  = ~frame[0];
            end else if (tmo_q == START_LAST) begin
               fail = 1'b1;
            end
         end
         S_DATA: begin
            if (fall) begin
               // falls #2..#10 carry bit_cnt 1..9; index 9 (stop) releases the line
               dat_oe_d  = ~frame[bit_cnt_q];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd9) state_d = S_ACK;
            end else if (tmo_q == FRAME_LAST) begin
               fail = 1'b1;
            end
         end
         S_ACK: begin
            if (fall) begin
               if (!dat_s2_q) state_d = S_DONE;
               else           fail    = 1'b1;
            end else if (tmo_q == FRAME_LAST) begin
               fail = 1'b1;
            end
         end
         default: state_d = S_IDLE;   // DONE and ERR last a single cycle
      endcase

      if (fail) begin
         tmo_d     = '0;
         bit_cnt_d = '0;
         if (RETRY_EN && (retry_q < RETRY_MAX)) begin
            state_d = S_INHIBIT;
            retry_d = retry_q + 4'd1;
         end else begin
            state_d = S_ERR;
         end
      end

      // data line is only ever driven during REQ/DATA/ACK
      if (state_d == S_IDLE || state_d == S_INHIBIT ||
          state_d == S_DONE || state_d == S_ERR) begin
         dat_oe_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         bit_cnt_q <= '0;
         tmo_q     <= '0;
         retry_q   <= '0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         bit_cnt_q <= bit_cnt_d;
         tmo_q     <= tmo_d;
         retry_q   <= retry_d;
         clk_oe_q  <= (state_d == S_INHIBIT);
         dat_oe_q  <= dat_oe_d;
         done_q    <= (state_d == S_DONE);
         err_q     <= (state_d == S_ERR);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign busy       = busy_q;
   assign tx_done    = done_q;
   assign tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Testbench for ps2_host_transmitter: directed frames against an open-drain device model.
// Device samples the data line while its clock is high, just before each fall.
// Expected frame words are hand-computed constants {stop, parity, data, start}.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;

   localparam int HALF = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;
   logic       ps2_clk_in, ps2_dat_in;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_host_transmitter #(
      .INHIBIT_CYCLES(50),
      .START_TIMEOUT (400),
      .FRAME_TIMEOUT (2000),
      .MAX_RETRIES   (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy      (busy),
      .tx_done   (tx_done),
      .tx_error  (tx_error)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // event monitors
   int done_cnt = 0, err_cnt = 0, inh_cur = 0, last_inh = 0, inh_runs = 0;
   always @(negedge clk) begin
      if (tx_done)  done_cnt <= done_cnt + 1;
      if (tx_error) err_cnt  <= err_cnt + 1;
      if (ps2_clk_oe) begin
         inh_cur <= inh_cur + 1;
      end else if (inh_cur != 0) begin
         last_inh <= inh_cur;
         inh_runs <= inh_runs + 1;
         inh_cur  <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] d, input string tag);
      check({tag, "_ready"}, {31'd0, tx_ready}, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check({tag, "_ready_low"}, {31'd0, tx_ready}, 0);
      check({tag, "_busy"}, {31'd0, busy}, 1);
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (busy && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_idle"}, {31'd0, busy}, 0);
      repeat (3) @(negedge clk);
   endtask

   // Device: waits for the request-to-send condition, then clocks nfalls falls.
   task automatic dev_frame(input logic ack, input int nfalls,
                            output logic [10:0] bits, output logic ok);
      int t;
      ok   = 1'b1;
      bits = '0;
      t    = 0;
      while (!(busy && !ps2_clk_oe && ps2_dat_oe) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         ok = 1'b0;
      end else begin
         repeat (10) @(negedge clk);
         for (int i = 0; i < nfalls; i++) begin
            bits[i] = ps2_dat_in;
            if (i == 10 && ack) dev_dat = 1'b0;
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
         end
         dev_dat = 1'b1;
      end
   endtask

   task automatic full_frame(input logic [7:0] d, input logic [10:0] exp_bits, input string tag);
      logic [10:0] bits;
      logic ok;
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send(d, tag);
      dev_frame(1'b1, 11, bits, ok);
      check({tag, "_req_seen"}, {31'd0, ok}, 1);
      check({tag, "_bits"}, {21'd0, bits}, {21'd0, exp_bits});
      wait_idle(tag);
      check({tag, "_done_pulse"}, done_cnt - d0, 1);
      check({tag, "_no_error"}, err_cnt - e0, 0);
   endtask

   initial begin
      logic [10:0] bits;
      logic ok;
      int d0, e0, r0, n;

      // ---- reset state
      repeat (3) @(negedge clk);
      check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
      check("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'd0, tx_ready}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, tx_done}, 0);
      check("rst_error", {31'd0, tx_error}, 0);
      repeat (2) @(negedge clk);

      // ---- 0xED: full ack frame, inhibit length, valid-while-busy ignored
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'hED, "ed");
      repeat (5) @(negedge clk);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      dev_frame(1'b1, 11, bits, ok);
      check("ed_req_seen", {31'd0, ok}, 1);
      check("ed_inhibit_len", last_inh, 50);
      check("ed_bits", {21'd0, bits}, 32'h7DA);
      wait_idle("ed");
      check("ed_done_pulse", done_cnt - d0, 1);
      check("ed_no_error", err_cnt - e0, 0);
      check("ed_ready_after", {31'd0, tx_ready}, 1);
      check("ed_clk_oe_after", {31'd0, ps2_clk_oe}, 0);
      check("ed_dat_oe_after", {31'd0, ps2_dat_oe}, 0);
      repeat (100) @(negedge clk);
      check("ed_ignored_valid", {31'd0, busy}, 0);

      // ---- parity corners
      full_frame(8'h01, 11'h402, "b01");
      full_frame(8'hFF, 11'h7FE, "bff");

`ifndef PS2_TX_RETRY_EN
      // ---- NACK
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'h3C, "nack");
      dev_frame(1'b0, 11, bits, ok);
      check("nack_req_seen", {31'd0, ok}, 1);
      check("nack_bits", {21'd0, bits}, 32'h678);
      wait_idle("nack");
      check("nack_error_pulse", err_cnt - e0, 1);
      check("nack_no_done", done_cnt - d0, 0);
      check("nack_clk_oe", {31'd0, ps2_clk_oe}, 0);
      check("nack_dat_oe", {31'd0, ps2_dat_oe}, 0);

      // ---- device never clocks: start timeout
      e0 = err_cnt;
      send(8'h55, "tmo");
      n = 0;
      while (!ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (!tx_error && n < 1000) begin @(negedge clk); n++; end
      check("tmo_latency", n, 400);
      check("tmo_clk_oe", {31'd0, ps2_clk_oe}, 0);
      check("tmo_dat_oe", {31'd0, ps2_dat_oe}, 0);
      wait_idle("tmo");
      check("tmo_error_pulse", err_cnt - e0, 1);
`endif

      // ---- async reset mid-frame (after fall #4, bit3 of 0xA5 is 0 -> dat driven low)
      send(8'hA5, "arst");
      dev_frame(1'b1, 4, bits, ok);
      check("arst_req_seen", {31'd0, ok}, 1);
      check("arst_dat_driven", {31'd0, ps2_dat_oe}, 1);
      #1 rst = 1'b1;
      #1;
      check("arst_clk_oe", {31'd0, ps2_clk_oe}, 0);
      check("arst_dat_oe", {31'd0, ps2_dat_oe}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("arst_ready", {31'd0, tx_ready}, 1);
      check("arst_busy", {31'd0, busy}, 0);
      full_frame(8'h5A, 11'h6B4, "post_rst");

`ifdef PS2_TX_RETRY_EN
      // ---- NACK then ACK: one retry, one tx_done
      d0 = done_cnt;
      e0 = err_cnt;
      r0 = inh_runs;
      send(8'hED, "retry1");
      dev_frame(1'b0, 11, bits, ok);
      check("retry1_first_req", {31'd0, ok}, 1);
      dev_frame(1'b1, 11, bits, ok);
      check("retry1_second_req", {31'd0, ok}, 1);
      check("retry1_bits", {21'd0, bits}, 32'h7DA);
      wait_idle("retry1");
      check("retry1_inhibits", inh_runs - r0, 2);
      check("retry1_done", done_cnt - d0, 1);
      check("retry1_no_error", err_cnt - e0, 0);

      // ---- three NACKs: single tx_error
      d0 = done_cnt;
      e0 = err_cnt;
      r0 = inh_runs;
      send(8'h01, "retry3");
      for (int k = 0; k < 3; k++) begin
         dev_frame(1'b0, 11, bits, ok);
         check("retry3_req", {31'd0, ok}, 1);
      end
      wait_idle("retry3");
      check("retry3_inhibits", inh_runs - r0, 3);
      check("retry3_error", err_cnt - e0, 1);
      check("retry3_no_done", done_cnt - d0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
